// File: rtl/serial_frame_scheduler_pkg.sv
// Shared types and sizes for the serial frame scheduler.
// Contents: state enumeration, requester count and field widths, and the
// packed record of one latched frame (port, length, payload).
package sched_pkg;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned PORT_W = 2;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned DATA_W = 15;

   typedef enum logic [2:0] {
      IDLE,
      START,
      PORT,
      LEN,
      DATA,
      GAP
   } state_t;

   // Frame captured at grant; data is shifted right as bits go out.
   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] data;
   } frame_t;

endpackage

// File: rtl/serial_frame_scheduler_if.sv
// Requester-side bus of the serial frame scheduler.
// Signals:
//   req        requests, one bit per requester (index = destination port)
//   len_i      4-bit lengths, requester i at [4i+3:4i]
//   data_i     15-bit payloads, requester i at [15i+14:15i]
//   gnt        one-hot grant pulse
//   busy       frame (including trailing gap) in progress
//   SerOut     serial line, idles high
//   frame_done pulse when the last data bit period ends
// Modports: master = requester side, slave = scheduler.
interface serial_frame_scheduler_if;
   import sched_pkg::*;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*LEN_W-1:0]  len_i;
   logic [N_REQ*DATA_W-1:0] data_i;
   logic [N_REQ-1:0]        gnt;
   logic                    busy;
   logic                    SerOut;
   logic                    frame_done;

   modport master (
      output req, len_i, data_i,
      input  gnt, busy, SerOut, frame_done
   );

   modport slave (
      input  req, len_i, data_i,
      output gnt, busy, SerOut, frame_done
   );

endinterface

// File: rtl/serial_frame_scheduler_rr_arbiter.sv
// Four-input one-hot arbiter for the serial frame scheduler.
// Macro SCHED_RR_EN: defined -> round-robin with a pointer register that
// moves one past the winner on each enabled grant; undefined -> fixed
// priority (requester 0 highest), no pointer and no clock ports.
// Ports:
//   clk, reset, en  (SCHED_RR_EN only) clock, async high reset, grant enable
//   elig            eligible requesters
//   gnt_c           one-hot winner (combinational)
//   idx_c           winner index (combinational)
//   any_c           at least one eligible requester (combinational)
module rr_arbiter
   import sched_pkg::*;
(
`ifdef SCHED_RR_EN
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
`endif
   input  logic [N_REQ-1:0]  elig,
   output logic [N_REQ-1:0]  gnt_c,
   output logic [PORT_W-1:0] idx_c,
   output logic              any_c
);

   logic [PORT_W-1:0] cand;

`ifdef SCHED_RR_EN
   logic [PORT_W-1:0] ptr_q;
   logic [PORT_W-1:0] ptr_d;

   // Scan from the far end back to the pointer so the nearest hit wins.
   always_comb begin
      cand  = '0;
      idx_c = '0;
      any_c = 1'b0;
      gnt_c = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         cand = ptr_q + PORT_W'(off);
         if (elig[cand]) begin
            idx_c = cand;
            any_c = 1'b1;
         end
      end
      gnt_c[idx_c] = any_c;
      ptr_d = ptr_q;
      if (en && any_c) begin
         ptr_d = idx_c + PORT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: lowest index wins.
   always_comb begin
      cand  = '0;
      idx_c = '0;
      any_c = 1'b0;
      gnt_c = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         cand = PORT_W'(off);
         if (elig[cand]) begin
            idx_c = cand;
            any_c = 1'b1;
         end
      end
      gnt_c[idx_c] = any_c;
   end
`endif

endmodule

// File: rtl/serial_frame_scheduler.sv
// Serial frame scheduler: arbitrates four requesters and serializes the
// winner as start(0), port[1:0] MSB first, len[3:0] MSB first, data LSB
// first, then GAP_BITS idle-high periods. Advances only on clkEN cycles.
// Macro SCHED_RR_EN selects round-robin arbitration (default: fixed
// priority, requester 0 highest).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   clkEN  single-cycle bit-step strobe
//   bus    serial_frame_scheduler_if.slave (req/len_i/data_i in,
//          gnt/busy/SerOut/frame_done out, all registered)
module serial_frame_scheduler
   import sched_pkg::*;
#(
   parameter int unsigned GAP_BITS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clkEN,
   serial_frame_scheduler_if.slave  bus
);

   state_t            state_q, state_d;
   frame_t            frame_q, frame_d;
   logic [LEN_W-1:0]  cnt_q,   cnt_d;
   logic              ser_q,   ser_d;
   logic              busy_q,  busy_d;
   logic [N_REQ-1:0]  gnt_q,   gnt_d;
   logic              done_q,  done_d;

   logic [N_REQ-1:0]  elig;
   logic [N_REQ-1:0]  arb_gnt_c;
   logic [PORT_W-1:0] arb_idx_c;
   logic              arb_any_c;

   // A zero-length request is ignored entirely.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = bus.req[i] && (bus.len_i[i*LEN_W +: LEN_W] != '0);
      end
   end

`ifdef SCHED_RR_EN
   logic arb_en;
   assign arb_en = clkEN && (state_q == IDLE);
`endif

   rr_arbiter u_arb (
`ifdef SCHED_RR_EN
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
`endif
      .elig  (elig),
      .gnt_c (arb_gnt_c),
      .idx_c (arb_idx_c),
      .any_c (arb_any_c)
   );

   // Next state: ser_d is the bit of the period being entered, so the line
   // only moves on clkEN edges. cnt_q counts bits left within a field.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      ser_d   = ser_q;
      busy_d  = busy_q;
      gnt_d   = '0;
      done_d  = 1'b0;
      if (clkEN) begin
         unique case (state_q)
            IDLE: begin
               ser_d = 1'b1;
               if (arb_any_c) begin
                  state_d       = START;
                  ser_d         = 1'b0;
                  busy_d        = 1'b1;
                  gnt_d         = arb_gnt_c;
                  frame_d.port  = arb_idx_c;
                  frame_d.len   = bus.len_i[arb_idx_c*LEN_W +: LEN_W];
                  frame_d.data  = bus.data_i[arb_idx_c*DATA_W +: DATA_W];
               end
            end
            START: begin
               state_d = PORT;
               cnt_d   = LEN_W'(PORT_W - 1);
               ser_d   = frame_q.port[PORT_W-1];
            end
            PORT: begin
               if (cnt_q == '0) begin
                  state_d = LEN;
                  cnt_d   = LEN_W'(LEN_W - 1);
                  ser_d   = frame_q.len[LEN_W-1];
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
                  ser_d = frame_q.port[cnt_d[0]];
               end
            end
            LEN: begin
               if (cnt_q == '0) begin
                  state_d = DATA;
                  cnt_d   = frame_q.len;
                  ser_d   = frame_q.data[0];
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
                  ser_d = frame_q.len[cnt_d[1:0]];
               end
            end
            DATA: begin
               if (cnt_q == LEN_W'(1)) begin
                  state_d = GAP;
                  cnt_d   = LEN_W'(GAP_BITS);
                  ser_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  cnt_d        = cnt_q - LEN_W'(1);
                  ser_d        = frame_q.data[1];
                  frame_d.data = frame_q.data >> 1;
               end
            end
            GAP: begin
               ser_d = 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               ser_d   = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         frame_q <= '0;
         cnt_q   <= '0;
         ser_q   <= 1'b1;
         busy_q  <= 1'b0;
         gnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.busy       = busy_q;
   assign bus.SerOut     = ser_q;
   assign bus.frame_done = done_q;

endmodule

// File: doc/serial_frame_scheduler.md
# serial_frame_scheduler

Transmit-side controller that shares one serial line among four requesters. It arbitrates their requests and serializes each granted payload into the multi-channel serial frame the receiver datapath decodes. The frame is a start bit, a 2-bit port, a 4-bit length and then the data bits. The block sits upstream of the receiver's SerIn, and bit timing is paced by the same one-pulsed `clkEN` strobe used throughout the lab design.

## Interface
Parameters:
- `GAP_BITS`, default 2. Number of idle-high bit periods inserted after every frame. Legal range is 1..15.

Ports:
- `clk` in, 1 bit. System clock. All logic is rising-edge.
- `reset` in, 1 bit. Asynchronous, active-high reset.
- `clkEN` in, 1 bit. Single-`clk` bit-step strobe. The FSM advances only on cycles where it is 1.
- `req` in, 4 bits. Request per requester. Requester index i is also its destination port.
- `len_i` in, 16 bits. Payload length, 4 bits per requester; requester i uses bits [4i+3:4i]. Legal values are 1..15.
- `data_i` in, 60 bits. Payload, 15 bits per requester; requester i uses bits [15i+14:15i].
- `gnt` out, 4 bits. One-hot, one-`clk` pulse marking the cycle in which the request was accepted.
- `busy` out, 1 bit. High from grant until the end of the gap.
- `SerOut` out, 1 bit. Serial line. Idles high.
- `frame_done` out, 1 bit. One-`clk` pulse on the cycle the last data bit period ends.

## Operation
- FSM states: IDLE, START, PORT, LEN, DATA, GAP. Every transition happens only on a `clk` edge where `clkEN`=1.
- **Eligibility:** requester i is eligible when `req[i]`=1 and its length is nonzero. A request with length 0 is never granted and never blocks other requesters.
- **IDLE:** on a `clkEN` cycle with at least one eligible requester:
  - select the winner;
  - pulse `gnt[winner]`;
  - latch the winner index, `len` and `data` into internal registers;
  - go to START.
  - With no eligible requester, stay in IDLE with `SerOut`=1.
- **START:** `SerOut`=0 for one bit period.
- **PORT:** the 2-bit winner index, MSB first, over 2 bit periods.
- **LEN:** the latched 4-bit length, MSB first, over 4 bit periods.
- **DATA:** `data[0]` through `data[len-1]`, LSB first, one bit period each. A 4-bit down-counter loaded with `len` ends the state.
- **GAP:** `SerOut`=1 for `GAP_BITS` bit periods, then return to IDLE.
- Total frame length is 7+len bit periods, plus `GAP_BITS` idle bit periods.
- **Latched inputs:** changes to `req`, `len_i` or `data_i` after the grant do not affect the frame in flight.
- **Held requests:** a requester that keeps `req` high after its grant is re-eligible in the next IDLE arbitration and is treated as a new frame.
- **Round-robin pointer:** points one past the last winner. Search order is pointer, pointer+1, …, wrapping 3→0. The pointer updates only on a grant.
- **Reset, including mid-frame:** immediately forces IDLE, `SerOut`=1, `gnt`=0, `busy`=0, `frame_done`=0, pointer=0 and counters cleared. The partially sent frame is abandoned with no completion pulse.

## Timing
- **`SerOut`:** registered. The START-bit low appears on the edge after the granting `clkEN` cycle.
- **Bit periods:** each bit is held from one `clkEN` edge to the next. The block never changes `SerOut` on cycles where `clkEN`=0.
- **`gnt` and `busy`:** `gnt` is asserted during the granting `clkEN` cycle only. `busy` rises on the same edge that `SerOut` first goes low.
- **`frame_done`:** asserted for the single `clk` cycle of the `clkEN` edge that moves DATA→GAP.
- **`busy` fall:** `busy` falls on the `clkEN` edge that moves GAP→IDLE. A new grant needs at least one further `clkEN` edge.
- **Simultaneous requests:** multiple eligible requests in one cycle are resolved by the round-robin pointer. No input is ever combinationally visible on an output.

## Configuration
- Macro `SCHED_RR_EN`.
- **Defined:** round-robin arbitration as described above.
- **Undefined:** fixed priority, requester 0 highest and 3 lowest. The pointer register is compiled out.

## Structure
- **Shared package `sched_pkg`:** state enumeration, `N_REQ`=4, `PORT_W`=2, `LEN_W`=4, `DATA_W`=15.
- **Sub-module `rr_arbiter`:** 4-input one-hot arbiter with grant-enable and pointer update. It is conditionally compiled for `SCHED_RR_EN`; otherwise it is a fixed-priority encoder.
- **Top level:** FSM, bit counters and the output shift mux.

## Test plan
- **Reset values:** with no requests, `SerOut` stays 1 and `busy` stays 0 for all `clkEN` strobes.
- **Single frame:** `req`=0001, `len0`=3, `data0`=3'b101, `GAP_BITS`=2.
  - `SerOut` per `clkEN` period is 0,0,0,0,0,1,1,1,0,1,1,1.
  - One `gnt`=0001 pulse and one `frame_done` pulse.
- **Round-robin:** `req`=1111 held for four frames with `SCHED_RR_EN` defined.
  - Grant order is 0,1,2,3.
  - Without the macro, every grant goes to requester 0.
- **Zero length:** `req`=0011 with `len0`=0 and `len1`=2.
  - Only requester 1 is granted.
  - Its port field reads 0,1.
- **Input change mid-frame:** change `data1` and `len1` during DATA.
  - Transmitted bits match the values latched at grant.
- **Reset mid-operation:** assert `reset` during LEN.
  - `SerOut` goes to 1 asynchronously and there is no `frame_done` pulse.
  - After release, the next grant goes to requester 0.
